// File: rtl/count_check_pkg.sv
// Shared types, default parameters and helper function for the count stream checker.
package count_check_pkg;

  // Checker state with fixed 2-bit encodings visible on state_o.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_LOSING = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_SYNC_LEN = 4;
  localparam int DEF_LOSS_LEN = 3;
  localparam int DEF_ERR_W    = 8;

  // Next value of the counter stream given the direction. Works on a
  // 32-bit container; callers compare only the low WIDTH bits, so the
  // wrap at 2^WIDTH falls out naturally.
  function automatic logic [31:0] next_expected(input logic [31:0] value,
                                                input logic        up);
    return up ? (value + 32'd1) : (value - 32'd1);
  endfunction

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up on inc, stop at all-ones, clear takes priority.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/count_stream_checker.sv
// Self-test reader for a free-running counter bus: hunts, syncs, locks onto
// a +/-1 stream and reports mismatches seen while locked.
module count_stream_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int LOSS_LEN = DEF_LOSS_LEN,
  parameter int ERR_W    = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             up,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_value,
  output logic [1:0]       state_o
);

  localparam int GW = (SYNC_LEN > 1) ? $clog2(SYNC_LEN + 1) : 1;
  localparam int BW = (LOSS_LEN > 1) ? $clog2(LOSS_LEN + 1) : 1;

  // Last in-run sample counts: reaching these completes sync / loss.
  localparam logic [GW-1:0] SYNC_LAST = GW'(SYNC_LEN - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_LEN - 1);

  // Mask selecting the WIDTH low bits of the 32-bit expected value.
  localparam logic [31:0] CMP_MASK = 32'((64'd1 << WIDTH) - 64'd1);

  state_t          state, state_nx;
  logic [GW-1:0]   good, good_nx;
  logic [BW-1:0]   bad, bad_nx;
  logic [31:0]     exp_full;
  logic            match;
  logic            err_det;

  // Compare the new sample against last_value stepped in the requested direction.
  always_comb begin
    exp_full = next_expected(32'(last_value), up);
    match    = ((exp_full ^ 32'(din)) & CMP_MASK) == 32'd0;
  end

  // Next-state and run-length bookkeeping; nothing moves without en.
  // NOTE: every signal gets a default before the case so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    bad_nx   = bad;
    err_det  = 1'b0;
    if (en) begin
      unique case (state)
        ST_HUNT: begin
          good_nx  = '0;
          state_nx = ST_SYNC;
        end
        ST_SYNC: begin
          if (match) begin
            if (good == SYNC_LAST) begin
              good_nx  = '0;
              state_nx = ST_LOCKED;
            end else begin
              good_nx = good + 1'b1;
            end
          end else begin
            good_nx = '0;
          end
        end
        ST_LOCKED: begin
          if (!match) begin
            err_det = 1'b1;
            if (LOSS_LEN == 1) begin
              bad_nx   = '0;
              state_nx = ST_HUNT;
            end else begin
              bad_nx   = BW'(1);
              state_nx = ST_LOSING;
            end
          end
        end
        ST_LOSING: begin
          if (match) begin
            bad_nx   = '0;
            state_nx = ST_LOCKED;
          end else begin
            err_det = 1'b1;
            if (bad == LOSS_LAST) begin
              bad_nx   = '0;
              state_nx = ST_HUNT;
            end else begin
              bad_nx = bad + 1'b1;
            end
          end
        end
        default: state_nx = ST_HUNT;
      endcase
    end
  end

  // State, run counters, sample history and the registered error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HUNT;
      good       <= '0;
      bad        <= '0;
      last_value <= '0;
      err_pulse  <= 1'b0;
    end else begin
      state     <= state_nx;
      good      <= good_nx;
      bad       <= bad_nx;
      err_pulse <= err_det;
      if (en) begin
        last_value <= din;
      end
    end
  end

  sat_counter #(
    .W (ERR_W)
  ) u_err_count (
    .clk (clk),
    .rst (rst),
    .inc (err_det),
    .clr (clear),
    .q   (err_count)
  );

  assign locked  = (state == ST_LOCKED) || (state == ST_LOSING);
  assign state_o = state;

endmodule
